// File: rtl/vga_sync_fsm.sv
// Raster sequencer: edge-detects the divider carry on qzt_clk and walks H/V ACTIVE/FRONT/SYNC/BACK states.
// Optional macro VGA_SYNC_POS_POLARITY_EN makes hsync/vsync active-high (default active-low).
module vga_sync_fsm #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       qzt_clk,
    input  logic       reset,
    input  logic       pix_tick,
    input  logic       enable,
    output logic       hsync,
    output logic       vsync,
    output logic       blank,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       line_start,
    output logic       frame_start
);

    typedef enum logic [1:0] {ST_ACTIVE, ST_FRONT, ST_SYNC, ST_BACK} state_e;

    // Totals above 1024 do not fit the 10-bit coordinates and are not supported.
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_FP_START = 10'(H_ACTIVE);
    localparam logic [9:0] H_SY_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_BP_START = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_FP_START = 10'(V_ACTIVE);
    localparam logic [9:0] V_SY_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_BP_START = 10'(V_ACTIVE + V_FP + V_SYNC);

`ifdef VGA_SYNC_POS_POLARITY_EN
    localparam logic SYNC_ON = 1'b1;
`else
    localparam logic SYNC_ON = 1'b0;
`endif

    logic       pix_tick_old_q;
    logic [9:0] x_q, x_d, y_q, y_d;
    state_e     h_state_q, h_state_d, v_state_q, v_state_d;
    logic       hsync_q, vsync_q, blank_q;
    logic       line_start_q, line_start_d, frame_start_q, frame_start_d;
    logic       tick;

    // Each state only ever moves to its successor, on reaching that successor's first position.
    function automatic state_e next_state(input state_e cur, input logic [9:0] pos,
                                          input logic [9:0] fp_start, input logic [9:0] sy_start,
                                          input logic [9:0] bp_start);
        state_e nxt;
        nxt = cur;
        case (cur)
            ST_ACTIVE: if (pos == fp_start) nxt = ST_FRONT;
            ST_FRONT:  if (pos == sy_start) nxt = ST_SYNC;
            ST_SYNC:   if (pos == bp_start) nxt = ST_BACK;
            ST_BACK:   if (pos == 10'd0)    nxt = ST_ACTIVE;
            default:   nxt = ST_ACTIVE;
        endcase
        return nxt;
    endfunction

    always_comb begin
        tick          = pix_tick & ~pix_tick_old_q & enable;
        x_d           = x_q;
        y_d           = y_q;
        h_state_d     = h_state_q;
        v_state_d     = v_state_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        if (tick) begin
            if (x_q == H_LAST) begin
                x_d           = 10'd0;
                line_start_d  = 1'b1;
                frame_start_d = (y_q == V_LAST);
                y_d           = (y_q == V_LAST) ? 10'd0 : y_q + 10'd1;
                v_state_d     = next_state(v_state_q, y_d, V_FP_START, V_SY_START, V_BP_START);
            end else begin
                x_d = x_q + 10'd1;
            end
            h_state_d = next_state(h_state_q, x_d, H_FP_START, H_SY_START, H_BP_START);
        end
    end

    // Sync/blank are registered from the next state so they line up with the new coordinates.
    always_ff @(posedge qzt_clk or posedge reset) begin
        if (reset) begin
            pix_tick_old_q <= 1'b0;
            x_q            <= 10'd0;
            y_q            <= 10'd0;
            h_state_q      <= ST_ACTIVE;
            v_state_q      <= ST_ACTIVE;
            hsync_q        <= ~SYNC_ON;
            vsync_q        <= ~SYNC_ON;
            blank_q        <= 1'b0;
            line_start_q   <= 1'b0;
            frame_start_q  <= 1'b0;
        end else begin
            pix_tick_old_q <= pix_tick;
            x_q            <= x_d;
            y_q            <= y_d;
            h_state_q      <= h_state_d;
            v_state_q      <= v_state_d;
            hsync_q        <= (h_state_d == ST_SYNC) ? SYNC_ON : ~SYNC_ON;
            vsync_q        <= (v_state_d == ST_SYNC) ? SYNC_ON : ~SYNC_ON;
            blank_q        <= (h_state_d != ST_ACTIVE) || (v_state_d != ST_ACTIVE);
            line_start_q   <= line_start_d;
            frame_start_q  <= frame_start_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign blank       = blank_q;
    assign x           = x_q;
    assign y           = y_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: doc/vga_sync_fsm.md
# vga_sync_fsm

Raster timing sequencer for the VGA test design, directly downstream of the 8-bit synchro counter used as pixel-clock divider. It consumes that counter's carry, a level held high for one divided period and sampled on `qzt_clk`, as the pixel tick. It walks horizontal and vertical state machines (ACTIVE, FRONT, SYNC, BACK) and emits hsync, vsync, blank, the pixel coordinates, and line/frame markers for the pattern generator.

## Interface
Parameters:
- `H_ACTIVE`, 640: visible pixels per line
- `H_FP`, 16: horizontal front porch, pixels
- `H_SYNC`, 96: hsync width, pixels
- `H_BP`, 48: horizontal back porch, pixels
- `V_ACTIVE`, 480: visible lines per frame
- `V_FP`, 10: vertical front porch, lines
- `V_SYNC`, 2: vsync width, lines
- `V_BP`, 33: vertical back porch, lines

Ports:
- `qzt_clk`  in  1  system clock; all state changes on its rising edge
- `reset`  in  1  asynchronous, active-high reset
- `pix_tick`  in  1  divider carry; each rising edge, detected on `qzt_clk`, advances one pixel
- `enable`  in  1  when low, detected ticks are ignored and all state is held
- `hsync`  out  1  horizontal sync; active-low by default
- `vsync`  out  1  vertical sync; active-low by default
- `blank`  out  1  high whenever either axis is outside ACTIVE
- `x`  out  10  horizontal position, 0..H_TOTAL-1
- `y`  out  10  vertical position, 0..V_TOTAL-1
- `line_start`  out  1  one-`qzt_clk` pulse when `x` wraps to 0
- `frame_start`  out  1  one-`qzt_clk` pulse when `x` and `y` both wrap to 0

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800). V_TOTAL is the analogous vertical sum (default 525). Both totals must be ≤ 1024; larger values are illegal configurations.
- Tick detection: an internal register `pix_tick_old` holds the previous sample. A tick is the condition `pix_tick & !pix_tick_old & enable`. A level held high yields exactly one tick.
- On each tick:
  - If `x` = H_TOTAL-1: `x` becomes 0 and the vertical axis advances.
  - Otherwise `x` increments by 1.
- Vertical advance:
  - If `y` = V_TOTAL-1: `y` becomes 0.
  - Otherwise `y` increments by 1.
- Horizontal state, derived from the new position:
  - ACTIVE: x < H_ACTIVE
  - FRONT: H_ACTIVE ≤ x < H_ACTIVE+H_FP
  - SYNC: H_ACTIVE+H_FP ≤ x < H_ACTIVE+H_FP+H_SYNC
  - BACK: the remainder
  - Transitions are strictly ACTIVE→FRONT→SYNC→BACK→ACTIVE.
- Vertical state machine: same scheme on `y`, with one transition at most per line wrap.
- `hsync` is asserted exactly while the horizontal state is SYNC; `vsync` exactly while the vertical state is SYNC.
- `blank` = (horizontal state ≠ ACTIVE) OR (vertical state ≠ ACTIVE).
- `line_start` is high for the single `qzt_clk` cycle following a tick that wrapped `x`. `frame_start` likewise, when `y` also wrapped. Both are otherwise 0.
- `enable` low: `pix_tick_old` still tracks `pix_tick`, so an edge occurring while disabled is lost, not deferred.
- `reset` asserted at any time, mid-line or mid-sync: immediate return to reset values, independent of `qzt_clk`. `reset` overrides a simultaneous tick.

## Timing
- Reset values:
  - x=0, y=0, both states ACTIVE
  - hsync=1, vsync=1 (deasserted)
  - blank=0, line_start=0, frame_start=0, pix_tick_old=0
- Latency: if the first `qzt_clk` edge sampling `pix_tick`=1 is edge N, then `x`, `y`, syncs and blank hold their new values after edge N. `line_start`/`frame_start` are high from edge N to edge N+1.
- All outputs are registered, with no combinational path from inputs.
- Minimum tick spacing is 2 `qzt_clk` cycles (high then low). A `pix_tick` toggling every cycle is therefore a tick every 2 cycles.

## Configuration
- `VGA_SYNC_POS_POLARITY_EN`:
  - Defined: `hsync`/`vsync` are active-high, with reset value 0.
  - Undefined (default): active-low, with reset value 1.
- No other behaviour changes.

## Test plan
- Reset, then hold `pix_tick` low for 20 cycles → x=0, y=0, hsync=1, vsync=1, blank=0, both pulses 0 throughout.
- 640 ticks → x=640, blank=1. Tick 656 → hsync=0. Tick 752 → hsync=1. Tick 800 → x=0, y=1, one-cycle `line_start`.
- 420000 ticks → vsync=0 after tick 392000 (y=490), vsync=1 after tick 393600 (y=492). After tick 420000: x=0, y=0, `frame_start` and `line_start` high for one cycle together.
- `pix_tick` held high for 50 cycles → exactly one increment. With `enable`=0, 10 edges → x unchanged.
- Assert `reset` asynchronously mid-hsync (x=700) → all outputs at reset values before the next `qzt_clk` edge. Tick coincident with reset release edge → ignored.
- Rebuild with `VGA_SYNC_POS_POLARITY_EN` → hsync reset 0, hsync=1 for x 656..751.
